// File: rtl/tdc_gate_pkg.sv
// Shared types and constants for the TDC gate sequencer.
// Phase lengths are clamped to MIN_PHASE; carry is blanked BLANK_CYC cycles.
package tdc_gate_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_GATE,
    S_HOLD
  } state_t;

  localparam int CNT_W     = 16;
  localparam int MIN_PHASE = 3;
  localparam int BLANK_CYC = 2;

endpackage

// File: rtl/tdc_gate_sequencer_len_to_preload.sv
// Clamp a phase length to [MIN_PHASE, CNT_MAX+MIN_PHASE] and derive the
// counter preload so the carry ends the phase after exactly N_c cycles.
module len_to_preload
  import tdc_gate_pkg::*;
#(
  parameter int CNT_MAX = 50000
) (
  input  logic [CNT_W-1:0] i_len,
  output logic [CNT_W-1:0] o_pre
);

  localparam int W1 = CNT_W + 1;
  localparam logic [CNT_W:0] LO = W1'(MIN_PHASE);
  localparam logic [CNT_W:0] HI = W1'(CNT_MAX + MIN_PHASE);

  logic [CNT_W:0] w_n;
  logic [CNT_W:0] w_nc;

  always_comb begin
    w_n  = {1'b0, i_len};
    w_nc = w_n;
    if (w_n < LO) begin
      w_nc = LO;
    end else if (w_n > HI) begin
      w_nc = HI;
    end
  end

  assign o_pre = CNT_W'(HI - w_nc);

endmodule

// File: rtl/tdc_gate_sequencer.sv
// Trigger-delay / gate / hold-off sequencer driving an external sync_counter.
// Define TDC_GATE_SEQ_HOLDOFF_EN to compile in the HOLD phase.
module tdc_gate_sequencer
  import tdc_gate_pkg::*;
#(
  parameter int CNT_MAX = 50000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             trig_req,
  output logic             trig_ack,
  input  logic             cal_req,
  output logic             cal_ack,
  input  logic             abort,
  input  logic [CNT_W-1:0] dly_len,
  input  logic [CNT_W-1:0] gate_len,
  input  logic [CNT_W-1:0] hold_len,
  output logic [CNT_W-1:0] cnt_d,
  output logic             cnt_ld,
  output logic             cnt_en,
  output logic             cnt_clr,
  input  logic             cnt_cy,
  output logic             gate,
  output logic             gate_src,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] BLANK = 2'(BLANK_CYC);

  state_t           r_state;
  logic [1:0]       r_blank;
  logic [CNT_W-1:0] r_gate_len;
  logic [CNT_W-1:0] r_hold_len;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_pre;
  logic             w_last;

  // Length of the phase about to be entered from the current state.
  always_comb begin
    w_len = dly_len;
    unique case (r_state)
      S_IDLE:  w_len = dly_len;
      S_DELAY: w_len = r_gate_len;
      default: w_len = r_hold_len;
    endcase
  end

  len_to_preload #(
    .CNT_MAX(CNT_MAX)
  ) u_pre (
    .i_len(w_len),
    .o_pre(w_pre)
  );

  // Carry right after a load still reflects the old count.
  assign w_last = (r_blank == 2'd0) && cnt_cy;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_blank    <= 2'd0;
      r_gate_len <= '0;
      r_hold_len <= '0;
      trig_ack   <= 1'b0;
      cal_ack    <= 1'b0;
      cnt_d      <= '0;
      cnt_ld     <= 1'b0;
      cnt_en     <= 1'b0;
      cnt_clr    <= 1'b0;
      gate       <= 1'b0;
      gate_src   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      trig_ack <= 1'b0;
      cal_ack  <= 1'b0;
      cnt_ld   <= 1'b0;
      cnt_clr  <= 1'b0;
      done     <= 1'b0;
      if (r_blank != 2'd0) begin
        r_blank <= r_blank - 2'd1;
      end
      if (r_state != S_IDLE && abort) begin
        r_state  <= S_IDLE;
        r_blank  <= 2'd0;
        cnt_en   <= 1'b0;
        cnt_clr  <= 1'b1;
        gate     <= 1'b0;
        gate_src <= 1'b0;
        busy     <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (!abort && (trig_req || cal_req)) begin
              r_state    <= S_DELAY;
              trig_ack   <= trig_req;
              cal_ack    <= !trig_req;
              gate_src   <= !trig_req;
              r_gate_len <= gate_len;
              r_hold_len <= hold_len;
              cnt_ld     <= 1'b1;
              cnt_d      <= w_pre;
              cnt_en     <= 1'b1;
              busy       <= 1'b1;
              r_blank    <= BLANK;
            end
          end
          S_DELAY: begin
            if (w_last) begin
              r_state <= S_GATE;
              cnt_ld  <= 1'b1;
              cnt_d   <= w_pre;
              gate    <= 1'b1;
              r_blank <= BLANK;
            end
          end
`ifdef TDC_GATE_SEQ_HOLDOFF_EN
          S_GATE: begin
            if (w_last) begin
              r_state <= S_HOLD;
              cnt_ld  <= 1'b1;
              cnt_d   <= w_pre;
              gate    <= 1'b0;
              r_blank <= BLANK;
            end
          end
          S_HOLD: begin
            if (w_last) begin
              r_state  <= S_IDLE;
              cnt_en   <= 1'b0;
              gate_src <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
`else
          S_GATE: begin
            if (w_last) begin
              r_state  <= S_IDLE;
              cnt_en   <= 1'b0;
              gate     <= 1'b0;
              gate_src <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdc_gate_sequencer.sv
// Self-checking bench for tdc_gate_sequencer with a behavioural counter
// and a timeline model of each accepted sequence.
module tb_tdc_gate_sequencer;

  localparam int CNT_MAX = 50000;
`ifdef TDC_GATE_SEQ_HOLDOFF_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic        clk;
  logic        clr;
  logic        trig_req;
  logic        trig_ack;
  logic        cal_req;
  logic        cal_ack;
  logic        abort;
  logic [15:0] dly_len;
  logic [15:0] gate_len;
  logic [15:0] hold_len;
  logic [15:0] cnt_d;
  logic        cnt_ld;
  logic        cnt_en;
  logic        cnt_clr;
  logic        cnt_cy;
  logic        gate;
  logic        gate_src;
  logic        busy;
  logic        done;

  logic [15:0] cnt;
  logic        tb_ld;
  logic [15:0] tb_val;

  int n_chk = 0;
  int n_fail = 0;

  tdc_gate_sequencer #(
    .CNT_MAX(CNT_MAX)
  ) dut (
    .clk(clk),
    .clr(clr),
    .trig_req(trig_req),
    .trig_ack(trig_ack),
    .cal_req(cal_req),
    .cal_ack(cal_ack),
    .abort(abort),
    .dly_len(dly_len),
    .gate_len(gate_len),
    .hold_len(hold_len),
    .cnt_d(cnt_d),
    .cnt_ld(cnt_ld),
    .cnt_en(cnt_en),
    .cnt_clr(cnt_clr),
    .cnt_cy(cnt_cy),
    .gate(gate),
    .gate_src(gate_src),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural sync_counter: carry is the registered cnt >= MAX.
  always @(posedge clk) begin
    if (clr || cnt_clr) cnt <= '0;
    else if (tb_ld) cnt <= tb_val;
    else if (cnt_ld) cnt <= cnt_d;
    else if (cnt_en) cnt <= cnt + 16'd1;
    cnt_cy <= clr ? 1'b0 : (cnt >= 16'(CNT_MAX));
  end

  function automatic int ncl(int n);
    if (n < 3) return 3;
    if (n > CNT_MAX + 3) return CNT_MAX + 3;
    return n;
  endfunction

  function automatic logic [15:0] pre(int n);
    return 16'(CNT_MAX + 3 - ncl(n));
  endfunction

  function automatic int total(int d, int g, int h);
    return ncl(d) + ncl(g) + (HOLD_EN ? ncl(h) : 0);
  endfunction

  // Expected {busy,gate,done,ld,trig_ack,cal_ack,en,clr} k cycles after request.
  function automatic logic [7:0] exp_ctl(int k, bit src, int d, int g, int h);
    int nd  = ncl(d);
    int ng  = ncl(g);
    int tot = total(d, g, h);
    bit bz  = (k >= 1) && (k <= tot);
    bit gt  = (k > nd) && (k <= nd + ng);
    bit dn  = (k == tot + 1);
    bit ld  = (k == 1) || (k == nd + 1) ||
              (HOLD_EN && (k == nd + ng + 1) && (k <= tot));
    return {bz, gt, dn, ld, (k == 1) && !src, (k == 1) && src, bz, 1'b0};
  endfunction

  function automatic logic [15:0] exp_d(int k, int d, int g, int h);
    if (k == 1) return pre(d);
    if (k == ncl(d) + 1) return pre(g);
    return pre(h);
  endfunction

  function automatic logic [7:0] obs();
    return {busy, gate, done, cnt_ld, trig_ack, cal_ack, cnt_en, cnt_clr};
  endfunction

  task automatic request(bit src, int d, int g, int h);
    dly_len  = 16'(d);
    gate_len = 16'(g);
    hold_len = 16'(h);
    if (src) cal_req = 1'b1;
    else trig_req = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({obs(), cnt_d, gate_src} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset outs got %b/%0d/%b want 0", obs(), cnt_d, gate_src);
    end
    clr = 1'b0;
    @(negedge clk);
    n_chk++;
    if (obs() !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_idle got %b want 0", obs());
    end
  endtask

  task automatic test_basic();
    logic [7:0] e;
    int d = 5, g = 4, h = 3;
    request(1'b0, d, g, h);
    for (int k = 1; k <= total(d, g, h) + 1; k++) begin
      @(negedge clk);
      e = exp_ctl(k, 1'b0, d, g, h);
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL basic k=%0d ctl got %b want %b", k, obs(), e);
      end
      if (e[4]) begin
        n_chk++;
        if (cnt_d !== exp_d(k, d, g, h)) begin
          n_fail++;
          $display("FAIL basic_d k=%0d got %0d want %0d", k, cnt_d, exp_d(k, d, g, h));
        end
      end
      if (k == 1) begin
        trig_req = 1'b0;
        dly_len  = 16'd40;
        gate_len = 16'd40;
        hold_len = 16'd40;
      end
    end
  endtask

  task automatic test_arbitration();
    logic [7:0] e;
    int d[2] = '{4, 6};
    int g[2] = '{3, 5};
    int h[2] = '{5, 0};
    request(1'b0, d[0], g[0], h[0]);
    cal_req = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int k = 1; k <= total(d[s], g[s], h[s]) + 1; k++) begin
        @(negedge clk);
        e = exp_ctl(k, s[0], d[s], g[s], h[s]);
        n_chk++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL arb s=%0d k=%0d ctl got %b want %b", s, k, obs(), e);
        end
        if (e[7]) begin
          n_chk++;
          if (gate_src !== s[0]) begin
            n_fail++;
            $display("FAIL arb_src s=%0d k=%0d got %b want %b", s, k, gate_src, s[0]);
          end
        end
        if (e[4]) begin
          n_chk++;
          if (cnt_d !== exp_d(k, d[s], g[s], h[s])) begin
            n_fail++;
            $display("FAIL arb_d s=%0d k=%0d got %0d want %0d", s, k, cnt_d,
                     exp_d(k, d[s], g[s], h[s]));
          end
        end
        if (k == 1 && s == 0) begin
          trig_req = 1'b0;
          dly_len  = 16'(d[1]);
          gate_len = 16'(g[1]);
          hold_len = 16'(h[1]);
        end
        if (k == 1 && s == 1) cal_req = 1'b0;
      end
    end
  endtask

  task automatic test_stale_carry();
    logic [7:0] e;
    int d = int'($urandom_range(3, 20));
    int g = 3, h = 4;
    tb_val = 16'd60000;
    tb_ld  = 1'b1;
    @(negedge clk);
    tb_ld = 1'b0;
    @(negedge clk);
    request(1'b1, d, g, h);
    for (int k = 1; k <= total(d, g, h) + 1; k++) begin
      @(negedge clk);
      e = exp_ctl(k, 1'b1, d, g, h);
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL stale d=%0d k=%0d ctl got %b want %b", d, k, obs(), e);
      end
      if (k == 1) cal_req = 1'b0;
    end
  endtask

  task automatic test_abort_clr();
    logic [7:0] e;
    int d = 5, g = 4, h = 3;
    request(1'b0, d, g, h);
    for (int k = 1; k <= ncl(d) + 2; k++) begin
      @(negedge clk);
      e = exp_ctl(k, 1'b0, d, g, h);
      n_chk++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL abort_pre k=%0d ctl got %b want %b", k, obs(), e);
      end
      if (k == 1) trig_req = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_chk++;
    if (obs() !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL abort_gate got %b want 00000001", obs());
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++;
      if (obs() !== 8'd0) begin
        n_fail++;
        $display("FAIL abort_after k=%0d got %b want 0", k, obs());
      end
    end
    request(1'b0, d, g, h);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_chk++;
    if (obs() !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_idle got %b want 0", obs());
    end
    @(negedge clk);
    trig_req = 1'b0;
    n_chk++;
    if (obs() !== exp_ctl(1, 1'b0, d, g, h)) begin
      n_fail++;
      $display("FAIL abort_release got %b want %b", obs(), exp_ctl(1, 1'b0, d, g, h));
    end
    @(negedge clk);
    clr = 1'b1;
    cal_req = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_chk++;
    if ({obs(), cnt_d, gate_src} !== 25'd0) begin
      n_fail++;
      $display("FAIL clr_mid got %b/%0d/%b want 0", obs(), cnt_d, gate_src);
    end
    @(negedge clk);
    cal_req = 1'b0;
    abort = 1'b1;
    n_chk++;
    if (obs() !== exp_ctl(1, 1'b1, d, g, h)) begin
      n_fail++;
      $display("FAIL clr_pending got %b want %b", obs(), exp_ctl(1, 1'b1, d, g, h));
    end
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    n_chk++;
    if (obs() !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_end got %b want 0", obs());
    end
  endtask

  task automatic test_random_back_to_back();
    logic [7:0] e;
    bit src;
    int d, g, h;
    for (int it = 0; it < 10; it++) begin
      src = 1'($urandom_range(0, 1));
      d = int'($urandom_range(0, 12));
      g = int'($urandom_range(0, 12));
      h = int'($urandom_range(0, 12));
      request(src, d, g, h);
      for (int k = 1; k <= total(d, g, h) + 1; k++) begin
        @(negedge clk);
        e = exp_ctl(k, src, d, g, h);
        n_chk++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL rand it=%0d k=%0d ctl got %b want %b", it, k, obs(), e);
        end
        if (e[4]) begin
          n_chk++;
          if (cnt_d !== exp_d(k, d, g, h)) begin
            n_fail++;
            $display("FAIL rand_d it=%0d k=%0d got %0d want %0d", it, k, cnt_d,
                     exp_d(k, d, g, h));
          end
        end
        if (e[7]) begin
          n_chk++;
          if (gate_src !== src) begin
            n_fail++;
            $display("FAIL rand_src it=%0d k=%0d got %b want %b", it, k, gate_src, src);
          end
        end
        if (k == 1) begin
          trig_req = 1'b0;
          cal_req  = 1'b0;
          dly_len  = 16'($urandom);
          gate_len = 16'($urandom);
          hold_len = 16'($urandom);
        end
      end
    end
  endtask

  task automatic test_clamp();
    logic [7:0] e;
    int d[2] = '{0, 65535};
    int g[2] = '{1, 0};
    int h = 2;
    for (int s = 0; s < 2; s++) begin
      request(1'b0, d[s], g[s], h);
      for (int k = 1; k <= total(d[s], g[s], h) + 1; k++) begin
        @(negedge clk);
        e = exp_ctl(k, 1'b0, d[s], g[s], h);
        n_chk++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL clamp s=%0d k=%0d ctl got %b want %b", s, k, obs(), e);
        end
        if (e[4]) begin
          n_chk++;
          if (cnt_d !== exp_d(k, d[s], g[s], h)) begin
            n_fail++;
            $display("FAIL clamp_d s=%0d k=%0d got %0d want %0d", s, k, cnt_d,
                     exp_d(k, d[s], g[s], h));
          end
        end
        if (k == 1) trig_req = 1'b0;
      end
    end
  endtask

  initial begin
    clr      = 1'b1;
    trig_req = 1'b0;
    cal_req  = 1'b0;
    abort    = 1'b0;
    dly_len  = '0;
    gate_len = '0;
    hold_len = '0;
    tb_ld    = 1'b0;
    tb_val   = '0;
    test_reset();
    test_basic();
    test_arbitration();
    test_stale_carry();
    test_abort_clr();
    test_random_back_to_back();
    test_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
